// File: rtl/prbs_pkg.sv
// Shared definitions for the 4-bit LFSR pattern generator and its checker.
// Both sides use lfsr_next so their sequences cannot drift apart.
package prbs_pkg;

   localparam int          LFSR_MAX_W   = 32;
   localparam int          DEFAULT_W    = 4;
   localparam logic [3:0]  DEFAULT_TAPS = 4'b1100;

   typedef enum logic {
      SEARCH = 1'b0,
      LOCKED = 1'b1
   } prbs_state_e;

   // next(w) = {w[width-2:0], ^(w & taps)}, computed on a zero-extended word.
   function automatic logic [LFSR_MAX_W-1:0] lfsr_next(
      input logic [LFSR_MAX_W-1:0] word,
      input logic [LFSR_MAX_W-1:0] taps,
      input int                    width = DEFAULT_W
   );
      logic [LFSR_MAX_W-1:0] mask;
      mask = (LFSR_MAX_W'(1) << width) - LFSR_MAX_W'(1);
      return ((word << 1) | LFSR_MAX_W'(^(word & taps))) & mask;
   endfunction

endpackage : prbs_pkg

// File: rtl/prbs_checker.sv
// Receive-side LFSR checker: self-seeds from the incoming word stream, locks after
// LOCK_CNT correct predictions, then free-runs and counts mismatches.
module prbs_checker
   import prbs_pkg::*;
#(
   parameter int               WIDTH      = DEFAULT_W,
   parameter logic [WIDTH-1:0] TAPS       = WIDTH'(DEFAULT_TAPS),
   parameter int               LOCK_CNT   = 8,
   parameter int               UNLOCK_ERR = 4,
   parameter int               CNT_W      = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_valid,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_clr_cnt,
   output logic             o_locked,
   output logic             o_err,
   output logic [CNT_W-1:0] o_err_cnt,
   output logic [WIDTH-1:0] o_expected
);

   localparam int MC_W = $clog2(LOCK_CNT + 1);
   localparam int ER_W = $clog2(UNLOCK_ERR + 1);

   prbs_state_e      state_q, state_d;
   logic             seed_valid_q, seed_valid_d;
   logic [MC_W-1:0]  match_cnt_q, match_cnt_d;
   logic [ER_W-1:0]  err_run_q, err_run_d;
   logic [WIDTH-1:0] exp_q, exp_d;
   logic             err_q, err_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic [WIDTH-1:0] data_next, exp_next;
   logic             locked_miss;

   assign data_next   = WIDTH'(lfsr_next(LFSR_MAX_W'(i_data), LFSR_MAX_W'(TAPS), WIDTH));
   assign exp_next    = WIDTH'(lfsr_next(LFSR_MAX_W'(exp_q), LFSR_MAX_W'(TAPS), WIDTH));
   assign locked_miss = i_valid && (state_q == LOCKED) && (i_data != exp_q);

   // NOTE: every register, including the prediction word, is cleared by the
   // async reset so a mid-run reset leaves no stale seed behind.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= SEARCH;
         seed_valid_q <= 1'b0;
         match_cnt_q  <= '0;
         err_run_q    <= '0;
         exp_q        <= '0;
         err_q        <= 1'b0;
         cnt_q        <= '0;
      end else begin
         state_q      <= state_d;
         seed_valid_q <= seed_valid_d;
         match_cnt_q  <= match_cnt_d;
         err_run_q    <= err_run_d;
         exp_q        <= exp_d;
         err_q        <= err_d;
         cnt_q        <= cnt_d;
      end
   end

   // NOTE: each comb-assigned signal gets its hold value first, so no path
   // through the case tree can infer a latch.
   always_comb begin
      state_d      = state_q;
      seed_valid_d = seed_valid_q;
      match_cnt_d  = match_cnt_q;
      err_run_d    = err_run_q;
      exp_d        = exp_q;
      if (i_valid) begin
         unique case (state_q)
            SEARCH: begin
               if (i_data == '0) begin
                  // All-zero is the LFSR lock-up word; never seed from it.
                  seed_valid_d = 1'b0;
                  match_cnt_d  = '0;
               end else if (!seed_valid_q) begin
                  exp_d        = data_next;
                  seed_valid_d = 1'b1;
                  match_cnt_d  = '0;
               end else if (i_data == exp_q) begin
                  exp_d       = data_next;
                  match_cnt_d = match_cnt_q + MC_W'(1);
                  if (match_cnt_q == MC_W'(LOCK_CNT - 1)) begin
                     state_d   = LOCKED;
                     err_run_d = '0;
                  end
               end else begin
                  exp_d       = data_next;
                  match_cnt_d = '0;
               end
            end
            LOCKED: begin
               // Free-run on the prediction so one bad word counts once.
               exp_d = exp_next;
               if (i_data == exp_q) begin
                  err_run_d = '0;
               end else if (err_run_q == ER_W'(UNLOCK_ERR - 1)) begin
                  state_d      = SEARCH;
                  seed_valid_d = 1'b0;
                  match_cnt_d  = '0;
                  err_run_d    = '0;
               end else begin
                  err_run_d = err_run_q + ER_W'(1);
               end
            end
            default: state_d = SEARCH;
         endcase
      end
   end

   always_comb begin
      err_d = locked_miss;
      cnt_d = cnt_q;
      if (i_clr_cnt) begin
         cnt_d = '0;
      end else if (locked_miss && (cnt_q != '1)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   assign o_locked   = (state_q == LOCKED);
   assign o_err      = err_q;
   assign o_err_cnt  = cnt_q;
   assign o_expected = exp_q;

endmodule : prbs_checker

// File: tb/tb_prbs_checker.sv
// Directed bench for prbs_checker: lock, single and burst errors, lock-up word,
// valid gaps with counter clear, and asynchronous reset during lock.
module tb_prbs_checker;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        i_valid = 1'b0;
   logic [3:0]  i_data = 4'h0;
   logic        i_clr_cnt = 1'b0;
   logic        o_locked;
   logic        o_err;
   logic [15:0] o_err_cnt;
   logic [3:0]  o_expected;

   // Reference sequence from 0001 with taps 1100, period 15.
   logic [3:0] seq [15] = '{4'h1, 4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD, 4'hA,
                            4'h5, 4'hB, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8};

   int pos    = 0;
   int errors = 0;
   int checks = 0;

   prbs_checker dut (
      .clk        (clk),
      .reset      (reset),
      .i_valid    (i_valid),
      .i_data     (i_data),
      .i_clr_cnt  (i_clr_cnt),
      .o_locked   (o_locked),
      .o_err      (o_err),
      .o_err_cnt  (o_err_cnt),
      .o_expected (o_expected)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drive one cycle of inputs, then sample 1 time unit after the rising edge.
   task automatic step(input logic v, input logic [3:0] d, input logic c);
      i_valid   = v;
      i_data    = d;
      i_clr_cnt = c;
      @(posedge clk);
      #1;
   endtask

   task automatic send_clean();
      step(1'b1, seq[pos % 15], 1'b0);
      pos++;
   endtask

   task automatic send_bad(input logic c);
      step(1'b1, ~seq[pos % 15], c);
      pos++;
   endtask

   initial begin
      int nvalid;
      int cyc;

      // Reset state
      #12;
      chk("rst_locked", 32'(o_locked), 32'd0);
      chk("rst_err", 32'(o_err), 32'd0);
      chk("rst_cnt", 32'(o_err_cnt), 32'd0);
      chk("rst_exp", 32'(o_expected), 32'd0);
      reset = 1'b1;

      // 1: clean stream, lock on the 9th word
      for (int k = 0; k < 9; k++) begin
         send_clean();
         chk("t1_err", 32'(o_err), 32'd0);
         chk("t1_locked", 32'(o_locked), 32'(k == 8));
         chk("t1_exp", 32'(o_expected), 32'(seq[(k + 1) % 15]));
      end
      chk("t1_cnt", 32'(o_err_cnt), 32'd0);
      chk("t1_exp_after_lock", 32'(o_expected), 32'hB);

      // 2: single substituted word 1011 -> 1010
      chk("t2_pos", 32'(seq[pos % 15]), 32'hB);
      step(1'b1, 4'hA, 1'b0);
      pos++;
      chk("t2_err", 32'(o_err), 32'd1);
      chk("t2_cnt", 32'(o_err_cnt), 32'd1);
      chk("t2_locked", 32'(o_locked), 32'd1);
      chk("t2_exp", 32'(o_expected), 32'h7);
      for (int k = 0; k < 3; k++) begin
         send_clean();
         chk("t2_err_after", 32'(o_err), 32'd0);
         chk("t2_cnt_after", 32'(o_err_cnt), 32'd1);
         chk("t2_locked_after", 32'(o_locked), 32'd1);
      end
      step(1'b0, 4'hF, 1'b0);
      chk("t2_idle_exp", 32'(o_expected), 32'(seq[pos % 15]));
      chk("t2_idle_err", 32'(o_err), 32'd0);

      // 3: clear, then a 4-word burst drops lock; 9 clean words relock
      step(1'b0, 4'h0, 1'b1);
      chk("t3_clr_cnt", 32'(o_err_cnt), 32'd0);
      chk("t3_clr_locked", 32'(o_locked), 32'd1);
      for (int k = 0; k < 4; k++) begin
         send_bad(1'b0);
         chk("t3_err", 32'(o_err), 32'd1);
         chk("t3_cnt", 32'(o_err_cnt), 32'(k + 1));
         chk("t3_locked", 32'(o_locked), 32'(k < 3));
      end
      for (int k = 0; k < 9; k++) begin
         send_clean();
         chk("t3_relock", 32'(o_locked), 32'(k == 8));
         chk("t3_relock_err", 32'(o_err), 32'd0);
      end
      chk("t3_cnt_final", 32'(o_err_cnt), 32'd4);

      // 4: reset, then 40 lock-up words
      reset = 1'b0;
      #2;
      reset = 1'b1;
      for (int k = 0; k < 40; k++) begin
         step(1'b1, 4'h0, 1'b0);
         chk("t4_locked", 32'(o_locked), 32'd0);
         chk("t4_exp", 32'(o_expected), 32'd0);
      end
      chk("t4_cnt", 32'(o_err_cnt), 32'd0);
      chk("t4_err", 32'(o_err), 32'd0);

      // 5: random valid gaps; lock after 9 valid words
      nvalid = 0;
      cyc    = 0;
      while (nvalid < 12 && cyc < 500) begin
         if ($urandom_range(0, 1) == 1) begin
            send_clean();
            nvalid++;
         end else begin
            step(1'b0, 4'h0, 1'b0);
         end
         cyc++;
         chk("t5_locked", 32'(o_locked), 32'(nvalid >= 9));
      end
      chk("t5_nvalid", 32'(nvalid), 32'd12);
      send_bad(1'b0);
      chk("t5_err", 32'(o_err), 32'd1);
      chk("t5_cnt", 32'(o_err_cnt), 32'd1);
      send_bad(1'b1);
      chk("t5_clr_err", 32'(o_err), 32'd1);
      chk("t5_clr_cnt", 32'(o_err_cnt), 32'd0);
      chk("t5_clr_locked", 32'(o_locked), 32'd1);
      send_clean();
      chk("t5_clean_err", 32'(o_err), 32'd0);
      chk("t5_clean_cnt", 32'(o_err_cnt), 32'd0);

      // 6: asynchronous reset between edges while locked
      send_bad(1'b0);
      #2;
      chk("t6_pre_err", 32'(o_err), 32'd1);
      chk("t6_pre_cnt", 32'(o_err_cnt), 32'd1);
      reset = 1'b0;
      #1;
      chk("t6_locked", 32'(o_locked), 32'd0);
      chk("t6_err", 32'(o_err), 32'd0);
      chk("t6_cnt", 32'(o_err_cnt), 32'd0);
      chk("t6_exp", 32'(o_expected), 32'd0);
      #2;
      reset = 1'b1;
      pos = 0;
      for (int k = 0; k < 9; k++) begin
         send_clean();
         chk("t6_relock", 32'(o_locked), 32'(k == 8));
      end
      chk("t6_relock_exp", 32'(o_expected), 32'hB);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_prbs_checker
